// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word holding register so that
// back-to-back words stream without an idle bit between them.
//
// state | meaning
// IDLE  | no word in flight; every edge is a load slot
// SHIFT | shifter drives ser_out; cnt is the index of the bit on the wire
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept;
  logic last_bit;
  logic load_slot;

  assign accept    = load_valid && !hold_full_q;
  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_slot = (state_q == IDLE) || (last_bit && shift_en);

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    if (load_slot) begin
      // The held word is older than anything on the bus, so it goes first.
      if (hold_full_q) begin
        shift_d     = hold_q;
        cnt_d       = '0;
        state_d     = SHIFT;
        hold_full_d = 1'b0;
      end else if (accept) begin
        shift_d = load_data;
        cnt_d   = '0;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (accept) begin
        hold_d      = load_data;
        hold_full_d = 1'b1;
      end
      if (shift_en) begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
    end
  end

  assign load_ready = !hold_full_q;
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign ser_last   = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: table-driven MSB-first sequences plus
// hand-written reset, LSB-first and reset-mid-word cases.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid, load_ready, shift_en;
  logic [7:0] load_data;
  logic       ser_out, ser_valid, ser_last;

  logic       lv2, rdy2, se2, out2, vld2, last2;
  logic [7:0] d2;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .shift_en(shift_en),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset),
    .load_valid(lv2), .load_ready(rdy2), .load_data(d2),
    .shift_en(se2),
    .ser_out(out2), .ser_valid(vld2), .ser_last(last2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       se;
    logic       rdy;
    logic       vld;
    logic       out;
    logic       last;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic [7:0] d, input logic se,
                     input logic rdy, input logic vld, input logic out, input logic last);
    vec_t v;
    v.lv = lv; v.d = d; v.se = se; v.rdy = rdy; v.vld = vld; v.out = out; v.last = last;
    tbl.push_back(v);
  endtask

  // Drive inputs, take one edge, and leave time 1 unit after it for sampling.
  task automatic apply(input logic lv, input logic [7:0] d, input logic se);
    load_valid = lv;
    load_data  = d;
    shift_en   = se;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic rdy, input logic vld,
                         input logic out, input logic last);
    chk({nm, " ready"}, load_ready, rdy);
    chk({nm, " valid"}, ser_valid, vld);
    chk({nm, " out"},   ser_out, out);
    chk({nm, " last"},  ser_last, last);
  endtask

  initial begin
    logic [7:0] wa, wb, wf, w1, w8;
    wa = 8'hA5; wb = 8'h3C; wf = 8'hF0; w1 = 8'h01; w8 = 8'h80;

    // Single word 0xA5, continuous shift_en.
    add(1'b1, wa, 1'b1, 1'b1, 1'b1, wa[7], 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, wa[7-k], k == 7);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back 0xA5 then 0x3C; 0x3C lands in hold on the second edge.
    add(1'b1, wa, 1'b1, 1'b1, 1'b1, wa[7], 1'b0);
    add(1'b1, wb, 1'b1, 1'b0, 1'b1, wa[6], 1'b0);
    for (int k = 2; k < 8; k++) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, wa[7-k], k == 7);
    for (int k = 0; k < 8; k++) add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, wb[7-k], k == 7);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall: 0xF0 with shift_en alternating, each bit held two cycles.
    add(1'b1, wf, 1'b1, 1'b1, 1'b1, wf[7], 1'b0);
    for (int s = 1; s < 16; s++)
      add(1'b0, 8'h00, (s % 2) == 0, 1'b1, 1'b1, wf[7 - (s / 2)], (s / 2) == 7);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; shift_en = 1'b0;
    lv2 = 1'b0; d2 = 8'h00; se2 = 1'b0;

    // Reset held: outputs clear, ready high, inputs ignored.
    #2;
    chk_out("in_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b1; load_data = 8'hFF; shift_en = 1'b1;
    @(posedge clk); #1;
    chk_out("reset_ignores_in", 1'b1, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk_out("after_release", 1'b1, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      apply(tbl[i].lv, tbl[i].d, tbl[i].se);
      chk_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].vld, tbl[i].out, tbl[i].last);
    end

    // Reset mid-word: 0xFF in flight, 0x55 held, async reset after 3 bits.
    apply(1'b1, 8'hFF, 1'b1);
    apply(1'b1, 8'h55, 1'b1);
    apply(1'b0, 8'h00, 1'b1);
    chk_out("mid_pre_reset", 1'b0, 1'b1, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk_out("mid_async_clear", 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    apply(1'b0, 8'h00, 1'b1);
    chk_out("mid_hold_dropped", 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, w8, 1'b1);
    chk_out("mid_w80_b0", 1'b1, 1'b1, w8[7], 1'b0);
    for (int k = 1; k < 8; k++) begin
      apply(1'b0, 8'h00, 1'b1);
      chk_out($sformatf("mid_w80_b%0d", k), 1'b1, 1'b1, w8[7-k], k == 7);
    end
    apply(1'b0, 8'h00, 1'b1);
    chk_out("mid_w80_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // LSB-first instance with 0x01.
    lv2 = 1'b1; d2 = w1; se2 = 1'b1;
    @(posedge clk); #1;
    lv2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lsb_b%0d valid", k), vld2, 1'b1);
      chk($sformatf("lsb_b%0d out", k), out2, w1[k]);
      chk($sformatf("lsb_b%0d last", k), last2, k == 7);
      @(posedge clk); #1;
    end
    chk("lsb_idle valid", vld2, 1'b0);
    chk("lsb_idle ready", rdy2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
